// File: rtl/notch_sample_feeder.sv
// notch_sample_feeder: buffers ADC strobes in a small FIFO and hands them one at a time to the notch filter.
// Latency: a sample written on edge E reaches data_in at E+1; the sample pulse is high from E+2 to E+3.
// Backpressure: none toward the ADC; a strobe on a full FIFO without a same-edge pop is dropped and counted.
// Optional NOTCH_FEED_OFFSET_BIN_EN: invert the sample MSB at FIFO write (offset-binary to two's complement).
module notch_sample_feeder #(
  parameter int DATA_SIZE  = 24,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_SIZE-1:0]          adc_data,
  input  logic                          adc_valid,
  output logic [DATA_SIZE-1:0]          data_in,
  output logic                          sample,
  input  logic                          filter_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overrun,
  output logic [15:0]                   overrun_cnt,
  output logic                          timeout_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic [DATA_SIZE-1:0]   data_in_q, data_in_d;
  logic                   sample_q, sample_d;
  logic                   overrun_q, overrun_d;
  logic [15:0]            overrun_cnt_q, overrun_cnt_d;
  logic                   timeout_err_q, timeout_err_d;
  logic [DATA_SIZE-1:0]   mem_q [FIFO_DEPTH];
  logic [DATA_SIZE-1:0]   mem_d [FIFO_DEPTH];

  logic                   pop;
  logic                   push;
  logic                   drop;
  logic                   full;
  logic [DATA_SIZE-1:0]   wr_dat;

`ifdef NOTCH_FEED_OFFSET_BIN_EN
  assign wr_dat = {~adc_data[DATA_SIZE-1], adc_data[DATA_SIZE-2:0]};
`else
  assign wr_dat = adc_data;
`endif

  // Sequencer: pop from IDLE, pulse from ISSUE, wait for done or timeout.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    data_in_d     = data_in_q;
    sample_d      = 1'b0;
    timeout_err_d = timeout_err_q;
    pop           = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (level_q != '0) begin
          pop       = 1'b1;
          data_in_d = mem_q[rd_ptr_q];
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        sample_d = 1'b1;
        timer_d  = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        // done takes priority over a timeout landing on the same edge
        if (filter_done) begin
          state_d = S_IDLE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO bookkeeping: a full FIFO still accepts a strobe when a pop frees a slot on the same edge.
  always_comb begin
    full          = (level_q == LW'(FIFO_DEPTH));
    push          = adc_valid && (!full || pop);
    drop          = adc_valid && full && !pop;
    wr_ptr_d      = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d      = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d       = level_q + LW'(push) - LW'(pop);
    overrun_d     = overrun_q | drop;
    overrun_cnt_d = overrun_cnt_q;
    if (drop && (overrun_cnt_q != 16'hFFFF)) begin
      overrun_cnt_d = overrun_cnt_q + 16'd1;
    end
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_dat;
    end
  end

  // Control and status registers; reset abandons any in-flight filter operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      data_in_q     <= '0;
      sample_q      <= 1'b0;
      overrun_q     <= 1'b0;
      overrun_cnt_q <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      data_in_q     <= data_in_d;
      sample_q      <= sample_d;
      overrun_q     <= overrun_d;
      overrun_cnt_q <= overrun_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Sample storage needs no reset; the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign data_in     = data_in_q;
  assign sample      = sample_q;
  assign fifo_level  = level_q;
  assign overrun     = overrun_q;
  assign overrun_cnt = overrun_cnt_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_notch_sample_feeder.sv
// tb_notch_sample_feeder: drives notch_sample_feeder with directed and random strobes.
// Reference: a transaction-level model (queue of samples plus per-sample done/timeout edge numbers).
// Filter done pulses are scheduled by the bench from the model's predicted sample edge.
module tb_notch_sample_feeder;

  localparam int DW    = 24;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] adc_data;
  logic          adc_valid;
  logic [DW-1:0] data_in;
  logic          sample;
  logic          filter_done;
  logic [LW-1:0] fifo_level;
  logic          overrun;
  logic [15:0]   overrun_cnt;
  logic          timeout_err;

  notch_sample_feeder #(
    .DATA_SIZE (DW),
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT   (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .data_in    (data_in),
    .sample     (sample),
    .filter_done(filter_done),
    .fifo_level (fifo_level),
    .overrun    (overrun),
    .overrun_cnt(overrun_cnt),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: edges are numbered; cyc is the last edge taken.
  int            cyc = 0;
  logic [DW-1:0] q[$];
  int            lat_q[$];
  int            fixed_lat = 0;
  bit            spur_en = 0;
  bit            has_flight = 0;
  bit            done_sched = 0;
  int            pop_edge = 0;
  int            sample_edge = -1;
  int            done_edge = -1;
  int            ready_edge = 0;
  logic [DW-1:0] m_data = '0;
  logic          m_sample = 1'b0;
  logic          m_ovr = 1'b0;
  logic [15:0]   m_cnt = '0;
  logic          m_to = 1'b0;

  function automatic logic [DW-1:0] conv(input logic [DW-1:0] d);
`ifdef NOTCH_FEED_OFFSET_BIN_EN
    return d ^ 24'h800000;
`else
    return d;
`endif
  endfunction

  // Cycles from the sample pulse to filter_done; above TMO means the filter never answers.
  function automatic int next_lat();
    if (lat_q.size() > 0) return lat_q.pop_front();
    if (fixed_lat > 0) return fixed_lat;
    return int'($urandom_range(1, TMO + 2));
  endfunction

  // Apply one edge of stimulus, advance the model, and leave time 1 unit after the edge.
  task automatic drive_cycle(input logic vld, input logic [DW-1:0] dat, input logic rst);
    int  t;
    int  n;
    int  lat;
    bit  popped;
    bit  done_now;
    t        = cyc + 1;
    done_now = has_flight && done_sched && (t == done_edge);
    if (!done_now && spur_en && !(has_flight && t >= pop_edge + 2 && t < ready_edge)
        && ($urandom_range(0, 3) == 0)) begin
      done_now = 1'b1;
    end
    reset       = rst;
    adc_valid   = vld;
    adc_data    = dat;
    filter_done = done_now;
    @(posedge clk);
    cyc = t;
    if (rst) begin
      q.delete();
      has_flight  = 0;
      done_sched  = 0;
      sample_edge = -1;
      done_edge   = -1;
      ready_edge  = 0;
      m_data      = '0;
      m_sample    = 1'b0;
      m_ovr       = 1'b0;
      m_cnt       = '0;
      m_to        = 1'b0;
    end else begin
      n        = q.size();
      popped   = (t >= ready_edge) && (n > 0);
      m_sample = (t == sample_edge);
      if (has_flight && !done_sched && (t == pop_edge + 1 + TMO)) m_to = 1'b1;
      if (popped) begin
        m_data      = q.pop_front();
        pop_edge    = t;
        sample_edge = t + 1;
        has_flight  = 1;
        lat         = next_lat();
        if (lat <= TMO) begin
          done_sched = 1;
          done_edge  = t + 1 + lat;
          ready_edge = t + 2 + lat;
        end else begin
          done_sched = 0;
          ready_edge = t + 2 + TMO;
        end
      end
      if (vld) begin
        if ((n < DEPTH) || popped) begin
          q.push_back(conv(dat));
        end else begin
          m_ovr = 1'b1;
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    drive_cycle(1'b0, '0, 1'b1);
    drive_cycle(1'b0, '0, 1'b1);
    checks++; if (data_in !== '0) begin errors++; $display("FAIL reset_data_in got %h want 0", data_in); end
    checks++; if (sample !== 1'b0) begin errors++; $display("FAIL reset_sample got %b want 0", sample); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
    checks++; if (overrun_cnt !== '0) begin errors++; $display("FAIL reset_ovr_cnt got %0d want 0", overrun_cnt); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", timeout_err); end
  endtask

  task automatic test_single();
    int pulses = 0;
    drive_cycle(1'b0, '0, 1'b1);
    fixed_lat = 5;
    spur_en   = 0;
    drive_cycle(1'b1, 24'h123456, 1'b0);
    checks++; if (sample !== 1'b0) begin errors++; $display("FAIL single_sample_e got %b want 0", sample); end
    drive_cycle(1'b0, '0, 1'b0);
    checks++; if (data_in !== conv(24'h123456)) begin errors++; $display("FAIL single_data_e1 got %h want %h", data_in, conv(24'h123456)); end
    checks++; if (sample !== 1'b0) begin errors++; $display("FAIL single_sample_e1 got %b want 0", sample); end
    drive_cycle(1'b0, '0, 1'b0);
    checks++; if (sample !== 1'b1) begin errors++; $display("FAIL single_sample_e2 got %b want 1", sample); end
    if (sample === 1'b1) pulses++;
    for (int i = 0; i < 12; i++) begin
      drive_cycle(1'b0, '0, 1'b0);
      if (sample === 1'b1) pulses++;
      checks++; if (data_in !== conv(24'h123456)) begin errors++; $display("FAIL single_hold cyc=%0d got %h want %h", cyc, data_in, conv(24'h123456)); end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL single_pulses got %0d want 1", pulses); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL single_level got %0d want 0", fifo_level); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL single_timeout got %b want 0", timeout_err); end
  endtask

  task automatic test_timeout();
    logic [DW-1:0] a, b;
    int            s_edge = -1;
    int            t_edge = -1;
    int            pulses = 0;
    logic [DW-1:0] seen[$];
    a = DW'($urandom);
    b = DW'($urandom);
    drive_cycle(1'b0, '0, 1'b1);
    fixed_lat = 3;
    lat_q.delete();
    lat_q.push_back(TMO + 1);
    drive_cycle(1'b1, a, 1'b0);
    drive_cycle(1'b1, b, 1'b0);
    for (int i = 0; i < 40; i++) begin
      drive_cycle(1'b0, '0, 1'b0);
      if (sample === 1'b1) begin
        pulses++;
        seen.push_back(data_in);
        if (s_edge < 0) s_edge = cyc;
      end
      if ((timeout_err === 1'b1) && (t_edge < 0)) t_edge = cyc;
      checks++; if (timeout_err !== m_to) begin errors++; $display("FAIL timeout_flag cyc=%0d got %b want %b", cyc, timeout_err, m_to); end
      checks++; if (sample !== m_sample) begin errors++; $display("FAIL timeout_sample cyc=%0d got %b want %b", cyc, sample, m_sample); end
    end
    checks++; if (t_edge - s_edge != 16) begin errors++; $display("FAIL timeout_delay got %0d want 16", t_edge - s_edge); end
    checks++; if (pulses != 2) begin errors++; $display("FAIL timeout_pulses got %0d want 2", pulses); end
    if (seen.size() == 2) begin
      checks++; if (seen[1] !== conv(b)) begin errors++; $display("FAIL timeout_next got %h want %h", seen[1], conv(b)); end
    end
  endtask

  task automatic test_overrun();
    logic [DW-1:0] v[6];
    logic [DW-1:0] seen[$];
    for (int i = 0; i < 6; i++) v[i] = DW'($urandom);
    drive_cycle(1'b0, '0, 1'b1);
    lat_q.delete();
    lat_q.push_back(TMO);
    fixed_lat = 3;
    drive_cycle(1'b1, v[0], 1'b0);
    drive_cycle(1'b0, '0, 1'b0);
    if (sample === 1'b1) seen.push_back(data_in);
    drive_cycle(1'b0, '0, 1'b0);
    if (sample === 1'b1) seen.push_back(data_in);
    for (int i = 1; i < 6; i++) begin
      drive_cycle(1'b1, v[i], 1'b0);
      if (sample === 1'b1) seen.push_back(data_in);
    end
    checks++; if (fifo_level !== LW'(4)) begin errors++; $display("FAIL ovr_level got %0d want 4", fifo_level); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", overrun); end
    checks++; if (overrun_cnt !== 16'd1) begin errors++; $display("FAIL ovr_cnt got %0d want 1", overrun_cnt); end
    for (int i = 0; i < 50; i++) begin
      drive_cycle(1'b0, '0, 1'b0);
      if (sample === 1'b1) seen.push_back(data_in);
      checks++; if (timeout_err !== m_to) begin errors++; $display("FAIL ovr_timeout cyc=%0d got %b want %b", cyc, timeout_err, m_to); end
      checks++; if (fifo_level !== LW'(q.size())) begin errors++; $display("FAIL ovr_drain_level cyc=%0d got %0d want %0d", cyc, fifo_level, q.size()); end
    end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL ovr_done_wins got %b want 0", timeout_err); end
    checks++; if (seen.size() != 5) begin errors++; $display("FAIL ovr_pulses got %0d want 5", seen.size()); end
    for (int i = 0; i < 5 && i < seen.size(); i++) begin
      checks++; if (seen[i] !== conv(v[i])) begin errors++; $display("FAIL ovr_order idx=%0d got %h want %h", i, seen[i], conv(v[i])); end
    end
  endtask

  task automatic test_full_pop();
    logic [DW-1:0] v[6];
    logic [DW-1:0] seen[$];
    bit            sent = 0;
    bit            vld;
    for (int i = 0; i < 6; i++) v[i] = DW'($urandom);
    drive_cycle(1'b0, '0, 1'b1);
    lat_q.delete();
    fixed_lat = 8;
    drive_cycle(1'b1, v[0], 1'b0);
    drive_cycle(1'b0, '0, 1'b0);
    drive_cycle(1'b0, '0, 1'b0);
    if (sample === 1'b1) seen.push_back(data_in);
    for (int i = 1; i < 5; i++) drive_cycle(1'b1, v[i], 1'b0);
    for (int i = 0; i < 70; i++) begin
      vld = !sent && (cyc + 1 == ready_edge) && (q.size() == DEPTH);
      drive_cycle(vld, v[5], 1'b0);
      if (sample === 1'b1) seen.push_back(data_in);
      if (vld) begin
        sent = 1;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL fullpop_overrun got %b want 0", overrun); end
        checks++; if (fifo_level !== LW'(4)) begin errors++; $display("FAIL fullpop_level got %0d want 4", fifo_level); end
        checks++; if (data_in !== conv(v[1])) begin errors++; $display("FAIL fullpop_popped got %h want %h", data_in, conv(v[1])); end
      end
    end
    checks++; if (!sent) begin errors++; $display("FAIL fullpop_window got 0 want 1"); end
    checks++; if (seen.size() != 6) begin errors++; $display("FAIL fullpop_pulses got %0d want 6", seen.size()); end
    for (int i = 0; i < 6 && i < seen.size(); i++) begin
      checks++; if (seen[i] !== conv(v[i])) begin errors++; $display("FAIL fullpop_order idx=%0d got %h want %h", i, seen[i], conv(v[i])); end
    end
  endtask

  task automatic test_reset_wait();
    int pulses = 0;
    drive_cycle(1'b0, '0, 1'b1);
    lat_q.delete();
    fixed_lat = TMO + 1;
    drive_cycle(1'b1, DW'($urandom), 1'b0);
    drive_cycle(1'b0, '0, 1'b0);
    drive_cycle(1'b0, '0, 1'b0);
    drive_cycle(1'b1, DW'($urandom), 1'b0);
    drive_cycle(1'b1, DW'($urandom), 1'b0);
    drive_cycle(1'b0, '0, 1'b0);
    drive_cycle(1'b0, '0, 1'b1);
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL rstwait_level got %0d want 0", fifo_level); end
    checks++; if (sample !== 1'b0) begin errors++; $display("FAIL rstwait_sample got %b want 0", sample); end
    checks++; if (data_in !== '0) begin errors++; $display("FAIL rstwait_data got %h want 0", data_in); end
    for (int i = 0; i < 30; i++) begin
      drive_cycle(1'b0, '0, 1'b0);
      if (sample === 1'b1) pulses++;
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rstwait_timeout cyc=%0d got %b want 0", cyc, timeout_err); end
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL rstwait_quiet got %0d want 0", pulses); end
    fixed_lat = 2;
    drive_cycle(1'b1, 24'h00ABCD, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b0, '0, 1'b0);
      if (sample === 1'b1) pulses++;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL rstwait_resume got %0d want 1", pulses); end
  endtask

  task automatic test_random();
    bit vld;
    drive_cycle(1'b0, '0, 1'b1);
    lat_q.delete();
    fixed_lat = 0;
    spur_en   = 1;
    for (int i = 0; i < 3000; i++) begin
      vld = (i < 1500) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 9) == 0);
      drive_cycle(vld, DW'($urandom), 1'b0);
      checks++; if (data_in !== m_data) begin errors++; $display("FAIL rand_data cyc=%0d got %h want %h", cyc, data_in, m_data); end
      checks++; if (sample !== m_sample) begin errors++; $display("FAIL rand_sample cyc=%0d got %b want %b", cyc, sample, m_sample); end
      checks++; if (fifo_level !== LW'(q.size())) begin errors++; $display("FAIL rand_level cyc=%0d got %0d want %0d", cyc, fifo_level, q.size()); end
      checks++; if (overrun !== m_ovr) begin errors++; $display("FAIL rand_overrun cyc=%0d got %b want %b", cyc, overrun, m_ovr); end
      checks++; if (overrun_cnt !== m_cnt) begin errors++; $display("FAIL rand_ovr_cnt cyc=%0d got %0d want %0d", cyc, overrun_cnt, m_cnt); end
      checks++; if (timeout_err !== m_to) begin errors++; $display("FAIL rand_timeout cyc=%0d got %b want %b", cyc, timeout_err, m_to); end
    end
    spur_en = 0;
  endtask

`ifdef NOTCH_FEED_OFFSET_BIN_EN
  task automatic test_offset();
    logic [DW-1:0] seen[$];
    drive_cycle(1'b0, '0, 1'b1);
    lat_q.delete();
    fixed_lat = 2;
    drive_cycle(1'b1, 24'h800000, 1'b0);
    drive_cycle(1'b1, 24'hFFFFFF, 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive_cycle(1'b0, '0, 1'b0);
      if (sample === 1'b1) seen.push_back(data_in);
    end
    checks++; if (seen.size() != 2) begin errors++; $display("FAIL offset_pulses got %0d want 2", seen.size()); end
    if (seen.size() == 2) begin
      checks++; if (seen[0] !== 24'h000000) begin errors++; $display("FAIL offset_first got %h want 000000", seen[0]); end
      checks++; if (seen[1] !== 24'h7FFFFF) begin errors++; $display("FAIL offset_second got %h want 7fffff", seen[1]); end
    end
  endtask
`endif

  initial begin
    reset       = 1'b1;
    adc_valid   = 1'b0;
    adc_data    = '0;
    filter_done = 1'b0;
    test_reset();
    test_single();
    test_timeout();
    test_overrun();
    test_full_pop();
    test_reset_wait();
    test_random();
`ifdef NOTCH_FEED_OFFSET_BIN_EN
    test_offset();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
